lab5_q2a_m: RTL and testbench

Prescaled, auto-reloading 16-bit down counter. A 5-bit prescaler divides the enabled clock by (psc+1) to produce a tick. Each tick decrements the counter, which reloads from `reload` after reaching zero and flags the wrap with `done`. The block serves as a periodic timer or event generator and is driven by a single system clock.

---
 rtl/lab5_q2a_m.sv | 48 ++++
 tb/tb_lab5_q2a_m.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/lab5_q2a_m.sv
// Prescaled auto-reloading 16-bit down counter: a 5-bit prescaler produces a tick
// every psc+1 enabled clocks, and each tick steps the counter, which reloads after 0.
module lab5_q2a_m (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  psc,
    input  logic [15:0] reload,
    output logic        tick,
    output logic [15:0] counter,
    output logic        done
);

    logic [4:0]  pcnt_q, pcnt_d;
    logic [15:0] counter_q, counter_d;
    logic        cnt_zero;

    assign cnt_zero = (counter_q == 16'h0000);

    // '>=' lets a lowered psc tick at once instead of wrapping pcnt through 31.
    assign tick    = en && (pcnt_q >= psc);
    assign done    = tick && cnt_zero;
    assign counter = counter_q;

    always_comb begin
        pcnt_d    = pcnt_q;
        counter_d = counter_q;
        if (en) begin
            if (tick) begin
                pcnt_d    = 5'd0;
                counter_d = cnt_zero ? reload : counter_q - 16'd1;
            end else begin
                pcnt_d    = pcnt_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt_q    <= 5'd0;
            counter_q <= 16'h0000;
        end else begin
            pcnt_q    <= pcnt_d;
            counter_q <= counter_d;
        end
    end

endmodule

// File: tb/tb_lab5_q2a_m.sv
// Bench for lab5_q2a_m: directed scenarios plus randomized traffic, checked against
// a cycle-count model of the prescaled timer.
module tb_lab5_q2a_m;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [4:0]  psc;
    logic [15:0] reload;
    logic        tick;
    logic [15:0] counter;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: enabled cycles since last tick, and the timer value.
    int m_pc  = 0;
    int m_cnt = 0;

    always #5 clk = ~clk;

    lab5_q2a_m dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .psc     (psc),
        .reload  (reload),
        .tick    (tick),
        .counter (counter),
        .done    (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Called just after a rising edge: drive, check at the falling edge, advance model.
    task automatic step(input logic e, input logic [4:0] p, input logic [15:0] r);
        logic et, ed;
        en = e; psc = p; reload = r;
        @(negedge clk);
        et = e && (m_pc >= int'(p));
        ed = et && (m_cnt == 0);
        chk("tick", {31'd0, tick}, {31'd0, et});
        chk("done", {31'd0, done}, {31'd0, ed});
        chk("counter", {16'd0, counter}, m_cnt);
        @(posedge clk);
        if (e) begin
            if (et) begin
                m_pc  = 0;
                m_cnt = (m_cnt == 0) ? int'(r) : m_cnt - 1;
            end else begin
                m_pc++;
            end
        end
        #1;
    endtask

    // Asynchronous reset pulse placed mid-cycle, checked before the next edge.
    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        m_pc  = 0;
        m_cnt = 0;
        chk("rst_counter", {16'd0, counter}, 0);
        chk("rst_tick", {31'd0, tick}, {31'd0, en && (psc == 5'd0)});
        chk("rst_done", {31'd0, done}, {31'd0, en && (psc == 5'd0)});
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; psc = 5'd0; reload = 16'd0;
        #3;
        chk("init_counter", {16'd0, counter}, 0);
        chk("init_tick", {31'd0, tick}, 0);
        chk("init_done", {31'd0, done}, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // psc=1, reload=10: done every 22 clocks
        for (int i = 0; i < 50; i++) step(1'b1, 5'd1, 16'd10);

        // psc=0, reload=3
        async_reset();
        for (int i = 0; i < 12; i++) step(1'b1, 5'd0, 16'd3);

        // reload=0, psc=2
        async_reset();
        for (int i = 0; i < 12; i++) step(1'b1, 5'd2, 16'd0);

        // en dropped for 7 cycles at counter=5, pcnt=1, psc=3
        en = 1'b1; psc = 5'd3;
        async_reset();
        begin
            int guard = 0;
            while (!(m_cnt == 5 && m_pc == 1) && guard < 200) begin
                step(1'b1, 5'd3, 16'd8);
                guard++;
            end
            chk("reach_cnt5", guard < 200, 1);
        end
        for (int i = 0; i < 7; i++) step(1'b0, 5'd3, 16'd8);
        chk("hold_counter", {16'd0, counter}, 5);
        for (int i = 0; i < 6; i++) step(1'b1, 5'd3, 16'd8);

        // psc lowered 20 -> 2 while pcnt=10
        async_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 5'd20, 16'd4);
        chk("pcnt10_state", m_pc, 10);
        for (int i = 0; i < 10; i++) step(1'b1, 5'd2, 16'd4);

        // reset mid-count at counter=7
        begin
            int guard = 0;
            while (m_cnt != 7 && guard < 200) begin
                step(1'b1, 5'd1, 16'd10);
                guard++;
            end
            chk("reach_cnt7", guard < 200, 1);
        end
        en = 1'b1; psc = 5'd1;
        async_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 5'd1, 16'd10);

        // randomized traffic
        begin
            logic [4:0]  rp = 5'd2;
            logic [15:0] rr = 16'd5;
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 29) == 0) rp = 5'($urandom_range(0, 7));
                if ($urandom_range(0, 63) == 0) rp = 5'($urandom_range(0, 31));
                if ($urandom_range(0, 19) == 0) rr = 16'($urandom_range(0, 6));
                if ($urandom_range(0, 199) == 0) begin
                    en = 1'b1; psc = rp;
                    async_reset();
                end
                step($urandom_range(0, 4) != 0, rp, rr);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        n_err++;
        $display("FAIL timeout: got running, expected finished");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "timeout");
    end

endmodule
